// File: rtl/kart_motion.sv
// kart_motion: once-per-frame heading/speed/position update feeding the track renderer.
// Optional build macro KART_REVERSE_EN: signed speed, allowing the kart to reverse.
module kart_motion #(
  parameter logic [10:0] START_X   = 11'd1024,
  parameter logic [10:0] START_Y   = 11'd1024,
  parameter logic [8:0]  START_DIR = 9'd90,
  parameter int          TURN_STEP = 4,
  parameter int          ACCEL     = 2,
  parameter int          BRAKE     = 4,
  parameter int          FRICTION  = 1,
  parameter int          MAX_SPEED = 64,
  parameter int          TRACK_MAX = 2047
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        frame_in,
  input  logic        btn_left_in,
  input  logic        btn_right_in,
  input  logic        btn_gas_in,
  input  logic        btn_brake_in,
  output logic [8:0]  direction_out,
  output logic [10:0] player_x_out,
  output logic [10:0] player_y_out,
  output logic [7:0]  speed_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        overrun_out
);

  localparam int unsigned DIR_W  = 9;
  localparam int unsigned INT_W  = 11;
  localparam int unsigned FRAC_W = 8;
  localparam int unsigned POS_W  = 19;
  localparam int unsigned TRIG_W = 11;
  localparam int unsigned SPD_W  = 9;
  localparam int unsigned PROD_W = 20;
  localparam int unsigned SUM_W  = 21;
  localparam int unsigned ROM_N  = 360;
  localparam int unsigned IDX_W  = 12;

  // sin of 0..90 degrees, fixed point scaled by 2^28, via Taylor series
  function automatic longint sin_fx(input int a);
    longint x, x2, term, acc;
    x    = (longint'(a) * longint'(843314857)) / longint'(180);
    x2   = (x * x) >>> 28;
    term = x;
    acc  = x;
    for (int k = 1; k < 10; k++) begin
      term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    return acc;
  endfunction

  function automatic logic signed [TRIG_W-1:0] trig_val(input int d);
    int     a;
    logic   neg;
    longint m;
    a   = d;
    neg = 1'b0;
    if (d > 270) begin
      a   = 360 - d;
      neg = 1'b1;
    end else if (d > 180) begin
      a   = d - 180;
      neg = 1'b1;
    end else if (d > 90) begin
      a = 180 - d;
    end
    m = (sin_fx(a) * longint'(512) + (longint'(1) <<< 27)) >>> 28;
    return neg ? TRIG_W'(-m) : TRIG_W'(m);
  endfunction

  function automatic logic [ROM_N*TRIG_W-1:0] gen_rom(input logic is_cos);
    logic [ROM_N*TRIG_W-1:0] r;
    r = '0;
    for (int d = 0; d < int'(ROM_N); d++)
      r[d*TRIG_W +: TRIG_W] = trig_val(is_cos ? (d + 90) % 360 : d);
    return r;
  endfunction

  localparam logic [ROM_N*TRIG_W-1:0] COS_ROM = gen_rom(1'b1);
  localparam logic [ROM_N*TRIG_W-1:0] SIN_ROM = gen_rom(1'b0);

  // Returns {clipped, position}; negative or past-edge integer parts pin to the border
  function automatic logic [POS_W:0] clamp_axis(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])
      return {1'b1, POS_W'(0)};
    else if (int'(s[SUM_W-2:FRAC_W]) > TRACK_MAX)
      return {1'b1, INT_W'(TRACK_MAX), FRAC_W'(0)};
    else
      return {1'b0, s[POS_W-1:0]};
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_TRIG0, S_TRIG1, S_MOVE, S_CLAMP} state_t;

  state_t                     state_q, state_nx;
  logic [3:0]                 btn_r;
  logic [DIR_W-1:0]           dir_r, rom_addr_q;
  logic signed [SPD_W-1:0]    spd_r;
  logic [POS_W-1:0]           posx_r, posy_r;
  logic signed [SUM_W-1:0]    sumx_r, sumy_r;
  logic signed [TRIG_W-1:0]   cos_q, sin_q;
  logic                       pend_q;

  logic [DIR_W-1:0]           dir_turn_c, rom_addr_c;
  logic signed [SPD_W-1:0]    spd_turn_c;
  logic [IDX_W-1:0]           rom_idx_c;
  logic signed [PROD_W-1:0]   prodx_c, prody_c, dx_c, dy_c;
  logic signed [SUM_W-1:0]    sumx_c, sumy_c;
  logic [POS_W:0]             clx_c, cly_c;
  logic                       accept_c, overrun_set_c;
  int                         d_i, s_i;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_nx = S_TURN;
      S_TURN:  state_nx = S_TRIG0;
      S_TRIG0: state_nx = S_TRIG1;
      S_TRIG1: state_nx = S_MOVE;
      S_MOVE:  state_nx = S_CLAMP;
      S_CLAMP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath controls: new heading/speed, ROM address, motion step and clamp
  always_comb begin
    accept_c      = (state_q == S_IDLE) && frame_in && !busy_out;
    overrun_set_c = frame_in && ((state_q != S_IDLE) || busy_out);

    d_i = int'(dir_r);
    if (btn_r[3] && !btn_r[2]) begin
      d_i = d_i + TURN_STEP;
      if (d_i >= 360) d_i = d_i - 360;
    end else if (btn_r[2] && !btn_r[3]) begin
      d_i = d_i - TURN_STEP;
      if (d_i < 0) d_i = d_i + 360;
    end
    dir_turn_c = DIR_W'(d_i);

    s_i = int'(spd_r);
`ifdef KART_REVERSE_EN
    if (btn_r[0]) begin
      if (s_i > 0) s_i = (s_i > BRAKE) ? s_i - BRAKE : 0;
      else         s_i = (s_i - BRAKE < -(MAX_SPEED / 2)) ? -(MAX_SPEED / 2) : s_i - BRAKE;
    end else if (btn_r[1]) begin
      s_i = (s_i < 0) ? s_i + BRAKE : s_i + ACCEL;
      if (s_i > MAX_SPEED) s_i = MAX_SPEED;
    end else if (s_i > 0) begin
      s_i = (s_i > FRICTION) ? s_i - FRICTION : 0;
    end else if (s_i < 0) begin
      s_i = (s_i < -FRICTION) ? s_i + FRICTION : 0;
    end
`else
    if (btn_r[0])      s_i = (s_i > BRAKE) ? s_i - BRAKE : 0;
    else if (btn_r[1]) s_i = (s_i + ACCEL > MAX_SPEED) ? MAX_SPEED : s_i + ACCEL;
    else               s_i = (s_i > FRICTION) ? s_i - FRICTION : 0;
`endif
    spd_turn_c = SPD_W'(s_i);

    rom_addr_c = (state_q == S_TURN) ? dir_turn_c : dir_r;
    rom_idx_c  = IDX_W'(rom_addr_q) * IDX_W'(TRIG_W);

    // Screen y grows downward, so a positive sine moves the kart up
    prodx_c = PROD_W'(spd_r) * PROD_W'(cos_q);
    prody_c = PROD_W'(spd_r) * PROD_W'(sin_q);
    dx_c    = prodx_c >>> 4;
    dy_c    = -(prody_c >>> 4);
    sumx_c  = $signed({2'b00, posx_r}) + SUM_W'(dx_c);
    sumy_c  = $signed({2'b00, posy_r}) + SUM_W'(dy_c);

    clx_c = clamp_axis(sumx_r);
    cly_c = clamp_axis(sumy_r);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      btn_r         <= '0;
      dir_r         <= START_DIR;
      spd_r         <= '0;
      posx_r        <= {START_X, FRAC_W'(0)};
      posy_r        <= {START_Y, FRAC_W'(0)};
      sumx_r        <= '0;
      sumy_r        <= '0;
      rom_addr_q    <= '0;
      cos_q         <= '0;
      sin_q         <= '0;
      pend_q        <= 1'b0;
      direction_out <= START_DIR;
      player_x_out  <= START_X;
      player_y_out  <= START_Y;
      speed_out     <= '0;
      valid_out     <= 1'b0;
      busy_out      <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      busy_out   <= (state_q != S_IDLE);
      rom_addr_q <= rom_addr_c;
      cos_q      <= COS_ROM[rom_idx_c +: TRIG_W];
      sin_q      <= SIN_ROM[rom_idx_c +: TRIG_W];
      if (overrun_set_c) overrun_out <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pend_q) begin
            pend_q        <= 1'b0;
            valid_out     <= 1'b1;
            direction_out <= dir_r;
            player_x_out  <= posx_r[POS_W-1:FRAC_W];
            player_y_out  <= posy_r[POS_W-1:FRAC_W];
            speed_out     <= spd_r[7:0];
          end
          if (accept_c) btn_r <= {btn_left_in, btn_right_in, btn_gas_in, btn_brake_in};
        end
        S_TURN: begin
          dir_r <= dir_turn_c;
          spd_r <= spd_turn_c;
        end
        S_MOVE: begin
          sumx_r <= sumx_c;
          sumy_r <= sumy_c;
        end
        S_CLAMP: begin
          posx_r <= clx_c[POS_W-1:0];
          posy_r <= cly_c[POS_W-1:0];
          if (clx_c[POS_W] || cly_c[POS_W]) spd_r <= '0;
          pend_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kart_motion.sv
// Directed bench for kart_motion: three instances with different start poses share stimulus.
module tb_kart_motion;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic frame_in = 1'b0;
  logic bl = 1'b0, br = 1'b0, bg = 1'b0, bb = 1'b0;

  logic [8:0]  dir_o   [3];
  logic [10:0] x_o     [3];
  logic [10:0] y_o     [3];
  logic [7:0]  spd_o   [3];
  logic        valid_o [3];
  logic        busy_o  [3];
  logic        ovr_o   [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  kart_motion #(.START_X(11'd1000), .START_Y(11'd1024), .START_DIR(9'd0)) u_a (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_in(frame_in),
    .btn_left_in(bl), .btn_right_in(br), .btn_gas_in(bg), .btn_brake_in(bb),
    .direction_out(dir_o[0]), .player_x_out(x_o[0]), .player_y_out(y_o[0]),
    .speed_out(spd_o[0]), .valid_out(valid_o[0]), .busy_out(busy_o[0]), .overrun_out(ovr_o[0]));

  kart_motion #(.START_DIR(9'd358), .TURN_STEP(3)) u_b (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_in(frame_in),
    .btn_left_in(bl), .btn_right_in(br), .btn_gas_in(bg), .btn_brake_in(bb),
    .direction_out(dir_o[1]), .player_x_out(x_o[1]), .player_y_out(y_o[1]),
    .speed_out(spd_o[1]), .valid_out(valid_o[1]), .busy_out(busy_o[1]), .overrun_out(ovr_o[1]));

  kart_motion #(.START_X(11'd1), .START_DIR(9'd180)) u_c (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_in(frame_in),
    .btn_left_in(bl), .btn_right_in(br), .btn_gas_in(bg), .btn_brake_in(bb),
    .direction_out(dir_o[2]), .player_x_out(x_o[2]), .player_y_out(y_o[2]),
    .speed_out(spd_o[2]), .valid_out(valid_o[2]), .busy_out(busy_o[2]), .overrun_out(ovr_o[2]));

  // btn = {left, right, gas, brake}
  typedef struct {
    int         inst;
    bit         rst;
    logic [3:0] btn;
    int         dir;
    int         x;
    int         y;
    int         spd;
  } vec_t;

  localparam logic [3:0] L = 4'b1000, R = 4'b0100, G = 4'b0010, B = 4'b0001, N = 4'b0000;
  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {bl, br, bg, bb} = b;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk_in);
    set_btn(v.btn);
    frame_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_in = 1'b0;
    set_btn(~v.btn);
    repeat (4) @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check($sformatf("v%0d_busy_n5", idx), int'(busy_o[v.inst]), 1);
    check($sformatf("v%0d_valid_n5", idx), int'(valid_o[v.inst]), 0);
    @(posedge clk_in);
    #1;
    check($sformatf("v%0d_valid_n6", idx), int'(valid_o[v.inst]), 1);
    check($sformatf("v%0d_dir", idx), int'(dir_o[v.inst]), v.dir);
    check($sformatf("v%0d_x", idx), int'(x_o[v.inst]), v.x);
    check($sformatf("v%0d_y", idx), int'(y_o[v.inst]), v.y);
    check($sformatf("v%0d_spd", idx), int'(spd_o[v.inst]), v.spd);
    set_btn(N);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;

    vecs[0]  = '{0, 1'b1, G,     0,   1000, 1024, 2};
    vecs[1]  = '{0, 1'b0, G,     0,   1000, 1024, 4};
    vecs[2]  = '{0, 1'b0, G,     0,   1001, 1024, 6};
    vecs[3]  = '{0, 1'b0, G,     0,   1002, 1024, 8};
    vecs[4]  = '{0, 1'b0, B,     0,   1003, 1024, 4};
    vecs[5]  = '{0, 1'b0, N,     0,   1003, 1024, 3};
    vecs[6]  = '{0, 1'b0, G | B, 0,   1003, 1024, 0};
    vecs[7]  = '{0, 1'b0, G,     0,   1003, 1024, 2};
    vecs[8]  = '{0, 1'b0, G,     0,   1004, 1024, 4};
    vecs[9]  = '{0, 1'b0, G,     0,   1004, 1024, 6};
    vecs[10] = '{0, 1'b0, N,     0,   1005, 1024, 5};
    vecs[11] = '{0, 1'b0, N,     0,   1006, 1024, 4};
    vecs[12] = '{0, 1'b0, L,     4,   1006, 1023, 3};
    vecs[13] = '{1, 1'b1, L,     1,   1024, 1024, 0};
    vecs[14] = '{1, 1'b0, R,     358, 1024, 1024, 0};
    vecs[15] = '{1, 1'b0, L | R, 358, 1024, 1024, 0};
    vecs[16] = '{2, 1'b1, G,     180, 0,    1024, 2};
    vecs[17] = '{2, 1'b0, G,     180, 0,    1024, 4};
    vecs[18] = '{2, 1'b0, G,     180, 0,    1024, 0};
    vecs[19] = '{2, 1'b0, G,     180, 0,    1024, 0};

    // reset state of every instance
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;
    check("rst_a_dir", int'(dir_o[0]), 0);
    check("rst_a_x", int'(x_o[0]), 1000);
    check("rst_a_y", int'(y_o[0]), 1024);
    check("rst_a_spd", int'(spd_o[0]), 0);
    check("rst_a_valid", int'(valid_o[0]), 0);
    check("rst_a_busy", int'(busy_o[0]), 0);
    check("rst_a_ovr", int'(ovr_o[0]), 0);
    check("rst_b_dir", int'(dir_o[1]), 358);
    check("rst_c_dir", int'(dir_o[2]), 180);
    check("rst_c_x", int'(x_o[2]), 1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) do_reset();
      run_vec(vecs[i], i);
    end

    // latency and overrun: frame at edge N, ignored second frame at N+2
    do_reset();
    @(negedge clk_in);
    set_btn(G);
    frame_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_in = 1'b0;
    set_btn(N);
    check("lat_busy_n0", int'(busy_o[0]), 0);
    @(posedge clk_in);
    #1;
    check("lat_busy_n1", int'(busy_o[0]), 1);
    check("lat_ovr_n1", int'(ovr_o[0]), 0);
    @(negedge clk_in);
    set_btn(B);
    frame_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_in = 1'b0;
    set_btn(N);
    check("lat_ovr_n2", int'(ovr_o[0]), 1);
    nvalid = 0;
    for (int e = 3; e <= 10; e++) begin
      @(posedge clk_in);
      #1;
      if (valid_o[0]) nvalid++;
      if (e == 5) check("lat_busy_n5", int'(busy_o[0]), 1);
      if (e == 6) begin
        check("lat_valid_n6", int'(valid_o[0]), 1);
        check("lat_busy_n6", int'(busy_o[0]), 0);
        check("lat_spd", int'(spd_o[0]), 2);
        check("lat_x", int'(x_o[0]), 1000);
      end
    end
    check("lat_valid_count", nvalid, 1);
    check("lat_ovr_sticky", int'(ovr_o[0]), 1);
    do_reset();
    #1;
    check("ovr_cleared", int'(ovr_o[0]), 0);

    // reset asserted between N+3 and N+4 aborts the update
    @(negedge clk_in);
    set_btn(G);
    frame_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_in = 1'b0;
    set_btn(N);
    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b0;
    #1;
    check("abort_dir", int'(dir_o[0]), 0);
    check("abort_x", int'(x_o[0]), 1000);
    check("abort_y", int'(y_o[0]), 1024);
    check("abort_spd", int'(spd_o[0]), 0);
    check("abort_busy", int'(busy_o[0]), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    nvalid = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk_in);
      #1;
      if (valid_o[0]) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    run_vec('{0, 1'b0, G, 0, 1000, 1024, 2}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
